my_if_responder: RTL and testbench

Memory-backed responder (target) end of the `my_if` valid/ready bus. It accepts single read/write requests from the bench-side initiator and inserts a configurable number of wait states. It stores writes in an internal register array and returns read data in the acknowledge cycle. It serves as the default DUT-side model for bus testbenches and as a simple register-file target in integration.

---
 rtl/my_if_responder_if.sv | 17 +
 rtl/my_if_responder.sv | 107 ++++++++++
 tb/tb_my_if_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/my_if_responder_if.sv
// Single-beat valid/ready request bus between an initiator (master) and a
// memory-backed responder (slave).
interface my_if_responder_if;
  // valid/ready: the master raises valid with addr/write/wdata and holds all
  // four stable until it sees ready=1 at a clock edge; the transfer completes
  // on that edge. ready is a one-cycle pulse and rdata is meaningful only
  // while ready=1 for a read.
  logic        valid;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, write, wdata, input ready, rdata);
  modport slave  (input valid, addr, write, wdata, output ready, rdata);
endinterface

// File: rtl/my_if_responder.sv
// Register-file responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, then acknowledges with a one-cycle ready pulse.
module my_if_responder #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  my_if_responder_if.slave    bus,
  output logic [15:0]         err_count,
  output logic [1:0]          dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          acc_err;
  logic          err_inc;
  logic          mem_we;

  // Misaligned or beyond the array: anything above the index bits is out of range.
  assign idx     = bus.addr[2 +: AW];
  assign acc_err = (|bus.addr[1:0]) || (|bus.addr[31:AW+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_inc = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.valid) begin
          state_d = S_IDLE;
          err_inc = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (acc_err) err_inc = 1'b1;
        else if (bus.write) mem_we = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_ACK);
    // Read data is captured on entry to ACK, so it never sees the write that
    // retires at the end of that same ACK cycle.
    rdata_d = '0;
    if (state_d == S_ACK && !bus.write) rdata_d = acc_err ? BAD_DATA : mem_q[idx];

    err_d = err_q;
    if (err_inc && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) mem_q[idx] <= bus.wdata;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_my_if_responder.sv
// Directed bench for my_if_responder: one instance with two wait states and
// one with none, read data checked through an expected queue.
module tb_my_if_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] err2, err0;
  logic [1:0]  st2, st0;

  my_if_responder_if b2 ();
  my_if_responder_if b0 ();

  my_if_responder #(.DEPTH(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b2), .err_count(err2), .dbg_state(st2)
  );

  my_if_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .err_count(err0), .dbg_state(st0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Driver for the WAIT_CYCLES=2 instance: full request/acknowledge with
  // latency and idle-rdata checks; read data comes from the expected queue.
  task automatic xfer2(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
    int lat;
    logic got;
    logic [31:0] e;
    @(negedge clk);
    b2.valid = 1'b1; b2.write = wr; b2.addr = a; b2.wdata = d;
    if (!wr) exp_q.push_back(exp_rd);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (b2.ready) got = 1'b1;
      else check("rdata_wait", b2.rdata, 32'h0);
    end
    if (!got) begin
      check("ready_timeout", 32'(got), 32'd1);
      if (!wr) void'(exp_q.pop_front());
    end else begin
      check("latency", 32'(lat), 32'd3);
      if (!wr) begin
        e = exp_q.pop_front();
        check("rdata_ack", b2.rdata, e);
      end
    end
    b2.valid = 1'b0;
    @(negedge clk);
    check("ready_low_after", 32'(b2.ready), 32'd0);
    check("rdata_low_after", b2.rdata, 32'h0);
  endtask

  initial begin
    b2.valid = 1'b0; b2.write = 1'b0; b2.addr = '0; b2.wdata = '0;
    b0.valid = 1'b0; b0.write = 1'b0; b0.addr = '0; b0.wdata = '0;
    rst_n = 1'b0;
    #12;
    check("rst_ready", 32'(b2.ready), 32'd0);
    check("rst_rdata", b2.rdata, 32'h0);
    check("rst_err", 32'(err2), 32'd0);
    check("rst_ready0", 32'(b0.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read with two wait states.
    xfer2(1'b1, 32'h8, 32'hA5A5_0001, 32'h0);
    xfer2(1'b0, 32'h8, 32'h0, 32'hA5A5_0001);

    // Error accesses must not touch the array (0x40 and 0x41 alias word 0).
    xfer2(1'b1, 32'h0, 32'h0000_CAFE, 32'h0);
    xfer2(1'b0, 32'h41, 32'h0, 32'hDEAD_BEEF);
    xfer2(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    xfer2(1'b1, 32'h40, 32'hFFFF_FFFF, 32'h0);
    check("err_after_bad", 32'(err2), 32'd3);
    xfer2(1'b0, 32'h0, 32'h0, 32'h0000_CAFE);
    xfer2(1'b0, 32'h8, 32'h0, 32'hA5A5_0001);

    // Abort: valid dropped during the second wait cycle of a write.
    xfer2(1'b1, 32'h4, 32'h1111_2222, 32'h0);
    @(negedge clk);
    b2.valid = 1'b1; b2.write = 1'b1; b2.addr = 32'h4; b2.wdata = 32'h9999_0000;
    @(negedge clk);
    check("abort_ready_w1", 32'(b2.ready), 32'd0);
    @(negedge clk);
    check("abort_ready_w2", 32'(b2.ready), 32'd0);
    b2.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(b2.ready), 32'd0);
    end
    check("abort_err", 32'(err2), 32'd4);
    xfer2(1'b0, 32'h4, 32'h0, 32'h1111_2222);

    // Zero wait states: fill words 0..3, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b0.valid = 1'b1; b0.write = 1'b1; b0.addr = 32'(i * 4); b0.wdata = 32'(i + 1);
      @(negedge clk);
      check("wc0_wr_ready", 32'(b0.ready), 32'd1);
      b0.valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    @(negedge clk);
    b0.valid = 1'b1; b0.write = 1'b0; b0.addr = 32'h0;
    begin
      int n;
      logic [31:0] e;
      n = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        check("wc0_ready_pattern", 32'(b0.ready), 32'(k % 2));
        if (b0.ready && n < 4) begin
          e = exp_q.pop_front();
          check("wc0_rdata", b0.rdata, e);
          n++;
          b0.addr = 32'(n * 4);
          if (n == 4) b0.valid = 1'b0;
        end else begin
          check("wc0_rdata_idle", b0.rdata, 32'h0);
        end
      end
      check("wc0_reads_done", 32'(n), 32'd4);
    end

    // Asynchronous reset in the middle of a write's wait phase.
    xfer2(1'b1, 32'hC, 32'h3333_3333, 32'h0);
    xfer2(1'b0, 32'hC, 32'h0, 32'h3333_3333);
    @(negedge clk);
    b2.valid = 1'b1; b2.write = 1'b1; b2.addr = 32'hC; b2.wdata = 32'h4444_4444;
    @(negedge clk);
    check("pre_rst_state", 32'(st2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(b2.ready), 32'd0);
    check("arst_rdata", b2.rdata, 32'h0);
    check("arst_err", 32'(err2), 32'd0);
    check("arst_state", 32'(st2), 32'd0);
    b2.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 16; w++) xfer2(1'b0, 32'(w * 4), 32'h0, 32'h0);

    // Saturation: preload the counter near the top, then keep erroring.
    @(negedge clk);
    force dut.err_q = 16'hFFFB;
    #1 release dut.err_q;
    for (int i = 0; i < 3; i++) xfer2(1'b0, 32'h41, 32'h0, 32'hDEAD_BEEF);
    check("sat_fffe", 32'(err2), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) xfer2(1'b0, 32'h41, 32'h0, 32'hDEAD_BEEF);
    check("sat_ffff", 32'(err2), 32'h0000_FFFF);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
